// File: rtl/mod_sched_pkg.sv
// Shared types and constants for the modulation segment scheduler and its
// transition trigger.
package mod_sched_pkg;

  localparam logic [15:0] REP_INFINITE = 16'hFFFF;

  typedef enum logic [7:0] {
    SYNC_IDX  = 8'h00,
    SYS_TIME  = 8'h01,
    GPIO      = 8'h02,
    IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN_INF,
    RUN_FIN,
    WAIT_TRANS,
    STOPPED
  } sched_state_t;

endpackage

// File: rtl/mod_transition_trigger.sv
// Evaluates the pending transition condition: sample-index wrap, system-time
// compare, GPIO rising edge, or unconditional for immediate/unknown modes.
module mod_transition_trigger
  import mod_sched_pkg::*;
#(
  parameter int SYS_TIME_W = 56
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            mode_i,
  input  logic [SYS_TIME_W-1:0] value_i,
  input  logic                  wrap_i,
  input  logic [SYS_TIME_W-1:0] sys_time_i,
  input  logic [3:0]            gpio_i,
  output logic                  fire_o
);

  logic [3:0] gpio_q;
  logic       gpio_rise;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_i;
    end
  end

  // A level already high when the request is latched does not count as an edge.
  assign gpio_rise = gpio_i[value_i[1:0]] & ~gpio_q[value_i[1:0]];

  always_comb begin
    fire_o = 1'b1;
    case (mode_i)
      SYNC_IDX: fire_o = wrap_i;
      SYS_TIME: fire_o = (sys_time_i >= value_i);
      GPIO:     fire_o = gpio_rise;
      default:  fire_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mod_segment_scheduler.sv
// Segment scheduler for the double-buffered modulation datapath: selects the
// active read segment, times requested switches and counts finite repetitions.
module mod_segment_scheduler
  import mod_sched_pkg::*;
#(
  parameter int IDX_W      = 15,
  parameter int SYS_TIME_W = 56
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  update_i,
  input  logic                  req_rd_segment_i,
  input  logic [63:0]           transition_i,
  input  logic [2*IDX_W-1:0]    cycle_i,
  input  logic [31:0]           rep_i,
  input  logic [IDX_W-1:0]      idx_in_i,
  input  logic [SYS_TIME_W-1:0] sys_time_i,
  input  logic [3:0]            gpio_in_i,
  output logic                  segment_o,
  output logic                  seg_changed_o,
  output logic                  stop_o,
  output logic                  busy_o
);

  sched_state_t          state_q, state_d;
  logic                  segment_q, segment_d;
  logic                  seg_changed_q, seg_changed_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;
  logic [15:0]           loop_cnt_q, loop_cnt_d;
  logic                  pend_seg_q, pend_seg_d;
  logic [7:0]            pend_mode_q, pend_mode_d;
  logic [SYS_TIME_W-1:0] pend_value_q, pend_value_d;
  logic [IDX_W-1:0]      prev_idx_q;
  logic [2*IDX_W-1:0]    cycle_q;

  logic [IDX_W-1:0]      active_cycle;
  logic [15:0]           active_rep;
  logic [15:0]           pend_rep;
  logic                  wrap;
  logic                  counting;
  logic                  fire;

  assign active_cycle = segment_q  ? cycle_q[2*IDX_W-1:IDX_W] : cycle_q[IDX_W-1:0];
  assign active_rep   = segment_q  ? rep_i[31:16] : rep_i[15:0];
  assign pend_rep     = pend_seg_q ? rep_i[31:16] : rep_i[15:0];

  assign wrap     = (prev_idx_q == active_cycle) && (idx_in_i == '0);
  assign counting = !stop_q &&
                    ((state_q == RUN_FIN) ||
                     ((state_q == WAIT_TRANS) && (active_rep != REP_INFINITE)));

  mod_transition_trigger #(
    .SYS_TIME_W (SYS_TIME_W)
  ) u_trigger (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .mode_i     (pend_mode_q),
    .value_i    (pend_value_q),
    .wrap_i     (wrap),
    .sys_time_i (sys_time_i),
    .gpio_i     (gpio_in_i),
    .fire_o     (fire)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= RUN_INF;
      segment_q     <= 1'b0;
      seg_changed_q <= 1'b0;
      stop_q        <= 1'b0;
      busy_q        <= 1'b0;
      loop_cnt_q    <= '0;
      pend_seg_q    <= 1'b0;
      pend_mode_q   <= '0;
      pend_value_q  <= '0;
      prev_idx_q    <= '0;
      cycle_q       <= '0;
    end else begin
      state_q       <= state_d;
      segment_q     <= segment_d;
      seg_changed_q <= seg_changed_d;
      stop_q        <= stop_d;
      busy_q        <= busy_d;
      loop_cnt_q    <= loop_cnt_d;
      pend_seg_q    <= pend_seg_d;
      pend_mode_q   <= pend_mode_d;
      pend_value_q  <= pend_value_d;
      prev_idx_q    <= idx_in_i;
      cycle_q       <= cycle_i;
    end
  end

  // Loop counting first; a new request or a switch later in this block takes
  // precedence, so a switch coinciding with a wrap clears instead of counts.
  always_comb begin
    state_d       = state_q;
    segment_d     = segment_q;
    seg_changed_d = 1'b0;
    stop_d        = stop_q;
    busy_d        = busy_q;
    loop_cnt_d    = loop_cnt_q;
    pend_seg_d    = pend_seg_q;
    pend_mode_d   = pend_mode_q;
    pend_value_d  = pend_value_q;

    if (wrap && counting) begin
      if (loop_cnt_q == active_rep) begin
        stop_d = 1'b1;
        if (state_q == RUN_FIN) begin
          state_d = STOPPED;
        end
      end else begin
        loop_cnt_d = loop_cnt_q + 16'd1;
      end
    end

    if (update_i) begin
      pend_seg_d   = req_rd_segment_i;
      pend_mode_d  = transition_i[63:56];
      pend_value_d = transition_i[SYS_TIME_W-1:0];
      busy_d       = 1'b1;
      state_d      = WAIT_TRANS;
    end else if ((state_q == WAIT_TRANS) && fire) begin
      segment_d     = pend_seg_q;
      seg_changed_d = 1'b1;
      stop_d        = 1'b0;
      loop_cnt_d    = '0;
      busy_d        = 1'b0;
      state_d       = (pend_rep == REP_INFINITE) ? RUN_INF : RUN_FIN;
    end
  end

  assign segment_o     = segment_q;
  assign seg_changed_o = seg_changed_q;
  assign stop_o        = stop_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mod_segment_scheduler.sv
// Self-checking bench for mod_segment_scheduler: directed sequences, a vector
// table for GPIO/override corners, and random traffic against a play-count model.
module tb_mod_segment_scheduler;
  import mod_sched_pkg::*;

  localparam int IDX_W      = 15;
  localparam int SYS_TIME_W = 56;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  update;
  logic                  reqSeg;
  logic [63:0]           transition;
  logic [2*IDX_W-1:0]    cycle;
  logic [31:0]           rep;
  logic [IDX_W-1:0]      idxIn;
  logic [SYS_TIME_W-1:0] sysTime;
  logic [3:0]            gpioIn;
  logic                  segment, segChanged, stop, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: active segment, play count, pending request.
  bit                    mSeg, mChg, mStop, mWaiting, mFinite, mPendSeg;
  logic [7:0]            mPendMode;
  logic [SYS_TIME_W-1:0] mPendVal;
  int                    mPlays;
  int unsigned           mPrev;
  int unsigned           mCyc[2];
  logic [3:0]            mGpioPrev;

  typedef struct {
    bit                    upd;
    bit                    req;
    logic [7:0]            mode;
    logic [SYS_TIME_W-1:0] val;
    logic [3:0]            gpio;
    logic [3:0]            exp;
    string                 name;
  } vec_t;

  vec_t tab[$];

  always #5 clk = ~clk;

  mod_segment_scheduler #(
    .IDX_W      (IDX_W),
    .SYS_TIME_W (SYS_TIME_W)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rstN),
    .update_i         (update),
    .req_rd_segment_i (reqSeg),
    .transition_i     (transition),
    .cycle_i          (cycle),
    .rep_i            (rep),
    .idx_in_i         (idxIn),
    .sys_time_i       (sysTime),
    .gpio_in_i        (gpioIn),
    .segment_o        (segment),
    .seg_changed_o    (segChanged),
    .stop_o           (stop),
    .busy_o           (busy)
  );

  function automatic int repOf(bit s);
    return s ? int'(rep[31:16]) : int'(rep[15:0]);
  endfunction

  function automatic vec_t mkVec(bit upd, bit req, logic [7:0] mode, int val,
                                 logic [3:0] gpio, logic [3:0] exp, string name);
    vec_t v;
    v.upd  = upd;
    v.req  = req;
    v.mode = mode;
    v.val  = SYS_TIME_W'(val);
    v.gpio = gpio;
    v.exp  = exp;
    v.name = name;
    return v;
  endfunction

  task automatic modelReset();
    mSeg = 0; mChg = 0; mStop = 0; mWaiting = 0; mFinite = 0; mPendSeg = 0;
    mPendMode = '0; mPendVal = '0; mPlays = 0; mPrev = 0;
    mCyc[0] = 0; mCyc[1] = 0; mGpioPrev = '0;
  endtask

  // One clock of the behavioural model: a play completes at each wrap; once
  // REP+1 plays are done the segment stops. Requests replace the pending one.
  task automatic modelStep();
    bit wrapEv, cond, doCount;
    int sel;
    wrapEv = (mPrev == mCyc[mSeg]) && (idxIn == 0);
    sel    = int'(mPendVal[1:0]);
    case (mPendMode)
      8'h00:   cond = wrapEv;
      8'h01:   cond = (sysTime >= mPendVal);
      8'h02:   cond = gpioIn[sel] && !mGpioPrev[sel];
      default: cond = 1'b1;
    endcase
    doCount = !mStop && (mWaiting ? (repOf(mSeg) != 65535) : mFinite);
    mChg = 0;
    if (doCount && wrapEv) begin
      mPlays++;
      if (mPlays > repOf(mSeg)) mStop = 1;
    end
    if (update) begin
      mPendSeg  = reqSeg;
      mPendMode = transition[63:56];
      mPendVal  = transition[SYS_TIME_W-1:0];
      mWaiting  = 1;
    end else if (mWaiting && cond) begin
      mSeg     = mPendSeg;
      mChg     = 1;
      mStop    = 0;
      mPlays   = 0;
      mWaiting = 0;
      mFinite  = (repOf(mPendSeg) != 65535);
    end
    mPrev     = idxIn;
    mCyc[0]   = cycle[IDX_W-1:0];
    mCyc[1]   = cycle[2*IDX_W-1:IDX_W];
    mGpioPrev = gpioIn;
  endtask

  // Clock edge, model update, then the sampler and system-time stimulus advance.
  task automatic tick();
    logic [IDX_W-1:0] lim;
    @(posedge clk);
    if (!rstN) modelReset();
    else modelStep();
    #1;
    sysTime = sysTime + 1;
    lim = mSeg ? cycle[2*IDX_W-1:IDX_W] : cycle[IDX_W-1:0];
    if (mChg || idxIn >= lim) idxIn = '0;
    else idxIn = idxIn + 1'b1;
  endtask

  task automatic applyStimulus(input bit upd, input bit req, input logic [7:0] mode,
                               input logic [SYS_TIME_W-1:0] val);
    update = upd;
    if (upd) begin
      reqSeg     = req;
      transition = {mode, val};
    end
    tick();
    update = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {segment, segChanged, stop, busy};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: seg/chg/stop/busy got %b expected %b at t=%0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; update = 1'b0; reqSeg = 1'b0; transition = '0;
    idxIn = '0; sysTime = '0; gpioIn = '0;
    cycle = {15'd4, 15'd3};
    rep   = {16'd2, 16'hFFFF};
    modelReset();
    tick();
    tick();
    checkOutput("reset_values", 4'b0000);
    rstN = 1'b1;

    $display("[TB] infinite loop on segment 0");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 8'h00, '0);
      if (i % 4 == 3) checkOutput("inf_loop", 4'b0000);
    end

    $display("[TB] immediate switch and finite repetition");
    applyStimulus(1, 1, 8'hFF, '0);
    checkOutput("imm_busy", 4'b0001);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("imm_switch", 4'b1100);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, 0, 8'h00, '0);
      if (k == 0)  checkOutput("seg1_chg_cleared", 4'b1000);
      if (k == 14) checkOutput("seg1_before_stop", 4'b1000);
    end
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("stop_third_wrap", 4'b1010);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 8'h00, '0);
    checkOutput("stop_held", 4'b1010);
    applyStimulus(1, 0, 8'hFF, '0);
    checkOutput("stopped_update", 4'b1011);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("stopped_exit", 4'b0100);

    $display("[TB] switch on sample-index wrap");
    applyStimulus(0, 0, 8'h00, '0);
    applyStimulus(1, 1, 8'h00, '0);
    checkOutput("sync_arm", 4'b0001);
    applyStimulus(0, 0, 8'h00, '0);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("sync_no_early", 4'b0001);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("sync_on_wrap", 4'b1100);

    $display("[TB] switch at system time");
    sysTime = 56'd990;
    applyStimulus(1, 0, 8'h01, 56'd1000);
    checkOutput("systime_arm", 4'b1001);
    while (sysTime != 56'd1000) applyStimulus(0, 0, 8'h00, '0);
    checkOutput("systime_early", 4'b1001);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("systime_fire", 4'b0100);
    sysTime = 56'd990;
    applyStimulus(1, 1, 8'h01, 56'd1000);
    while (sysTime != 56'd995) applyStimulus(0, 0, 8'h00, '0);
    applyStimulus(1, 1, 8'h01, 56'd2000);
    while (sysTime != 56'd1001) applyStimulus(0, 0, 8'h00, '0);
    checkOutput("systime_replaced", 4'b0001);
    while (sysTime != 56'd2000) applyStimulus(0, 0, 8'h00, '0);
    checkOutput("systime_2000_early", 4'b0001);
    applyStimulus(0, 0, 8'h00, '0);
    checkOutput("systime_2000", 4'b1100);

    $display("[TB] GPIO edge and override table");
    tab.push_back(mkVec(1, 0, 8'h02, 2, 4'b0000, 4'b1001, "gpio_arm"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0010, 4'b1001, "gpio_bit1"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0000, 4'b1001, "gpio_idle"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0100, 4'b0100, "gpio_bit2"));
    tab.push_back(mkVec(1, 1, 8'h02, 2, 4'b0100, 4'b0001, "gpio_arm_held"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0100, 4'b0001, "gpio_held1"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0100, 4'b0001, "gpio_held2"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0000, 4'b0001, "gpio_low"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0100, 4'b1100, "gpio_reedge"));
    tab.push_back(mkVec(1, 0, 8'h02, 0, 4'b0000, 4'b1001, "ovr_arm"));
    tab.push_back(mkVec(1, 0, 8'h02, 3, 4'b0001, 4'b1001, "ovr_update_wins"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b0001, 4'b1001, "ovr_old_dropped"));
    tab.push_back(mkVec(0, 0, 8'h00, 0, 4'b1001, 4'b0100, "ovr_new_fires"));
    for (int i = 0; i < tab.size(); i++) begin
      gpioIn = tab[i].gpio;
      applyStimulus(tab[i].upd, tab[i].req, tab[i].mode, tab[i].val);
      checkOutput(tab[i].name, tab[i].exp);
    end

    $display("[TB] reset while a request is pending");
    applyStimulus(1, 1, 8'h01, 56'hFF_FFFF_FFFF_FFFF);
    checkOutput("midop_busy", 4'b0001);
    rstN = 1'b0;
    #1;
    checkOutput("reset_midop", 4'b0000);
    modelReset();
    idxIn = '0;
    gpioIn = '0;
    cycle = {15'($urandom_range(1, 5)), 15'($urandom_range(1, 5))};
    rep   = {($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3))};
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 8'h00, '0);
    checkOutput("reset_pending_lost", 4'b0000);

    $display("[TB] random traffic against reference model");
    for (int c = 0; c < 600; c++) begin
      logic [7:0]            m;
      logic [SYS_TIME_W-1:0] v;
      int                    gi;
      if ($urandom_range(0, 3) == 0) begin
        gi = int'($urandom_range(0, 3));
        gpioIn[gi] = ~gpioIn[gi];
      end
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0:       m = 8'h00;
          1:       m = 8'h01;
          2:       m = 8'h02;
          3:       m = 8'hFF;
          default: m = 8'h5A;
        endcase
        if (m == 8'h01) v = sysTime + SYS_TIME_W'($urandom_range(0, 30)) - 56'd5;
        else v = SYS_TIME_W'($urandom_range(0, 3));
        applyStimulus(1, 1'($urandom_range(0, 1)), m, v);
      end else begin
        applyStimulus(0, 0, 8'h00, '0);
      end
      checkOutput("random", {mSeg, mChg, mStop, mWaiting});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_segment_scheduler.md
Name: mod_segment_scheduler

Overview:
- Sequences the double-buffered modulation datapath: decides which of the two segments the modulation sampler reads.
- Decides when a requested segment change takes effect (immediate, on sample-index wrap, at a system time, or on a GPIO edge).
- Counts finite repetitions and asserts STOP once the last loop completes.
- Sits between the controller's mod_settings_t output and the modulation sampler/memory read port.

Parameters:
- IDX_W, 15, width of sample index and CYCLE fields.
- SYS_TIME_W, 56, width of system-time compare value.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- UPDATE  in  1  one-cycle pulse: latch new request
- REQ_RD_SEGMENT  in  1  requested segment
- TRANSITION  in  64  [63:56] mode, [55:0] mode value
- CYCLE  in  2x15  per-segment last sample index (samples-1)
- REP  in  2x16  per-segment repeat count; 16'hFFFF = infinite
- IDX_IN  in  15  current sample index from sampler
- SYS_TIME  in  56  free-running system time
- GPIO_IN  in  4  external trigger inputs, already synchronised
- SEGMENT  out  1  active read segment
- SEG_CHANGED  out  1  one-cycle pulse on switch; sampler restarts index at 0
- STOP  out  1  finite repetition exhausted; sampler holds last sample
- BUSY  out  1  transition pending

Behaviour:
- Reset values: SEGMENT=0, SEG_CHANGED=0, STOP=0, BUSY=0. State=RUN_INF, loop counter=0, prev_idx=0.
- Wrap event: registered prev_idx==CYCLE[SEGMENT] and IDX_IN==0. The comparison uses registered CYCLE of the active segment.
- Transition modes:
  - 8'h00 SYNC_IDX: switch on next wrap event.
  - 8'h01 SYS_TIME: switch when SYS_TIME >= value[55:0] (unsigned).
  - 8'h02 GPIO: switch on rising edge of GPIO_IN[value[1:0]]. Edge detected against a 1-cycle delayed copy.
  - 8'hFF IMMEDIATE: switch with no condition.
  - Any other mode is treated as IMMEDIATE.
- States:
  - RUN_INF: REP[SEGMENT]==FFFF; loops forever.
  - RUN_FIN: counting loops.
  - WAIT_TRANS: pending request; current segment keeps playing and counting.
  - STOPPED: STOP=1.
- UPDATE in any state: latch REQ_RD_SEGMENT, mode and value into pending registers, then go to WAIT_TRANS (BUSY=1 next cycle).
  - IMMEDIATE: the condition evaluates true in the first WAIT_TRANS cycle.
  - Switch occurs 2 cycles after UPDATE.
- Switch cycle:
  - SEGMENT<=pending segment; SEG_CHANGED=1 for one cycle.
  - STOP<=0, loop counter<=0, BUSY<=0.
  - Next state RUN_INF if REP[new]==FFFF, else RUN_FIN.
- Requesting the currently active segment is legal: it restarts playback and the repetition count.
- RUN_FIN: each wrap event increments the loop counter. When counter==REP[SEGMENT] at a wrap, go to STOPPED and assert STOP. Total plays = REP+1.
- REP=0: STOP asserts at the first wrap.
- Loop counter width 16; it never wraps, because FFFF is excluded from RUN_FIN.
- STOPPED: ignore wrap events. Leave only via UPDATE.
- UPDATE during WAIT_TRANS: new request overwrites pending; the condition re-evaluates from the next cycle. The old request is discarded.
- Transition condition true in the same cycle as UPDATE: UPDATE wins; the pending request is replaced and no switch happens that cycle.
- Wrap and switch in the same cycle: switch wins; the loop counter is cleared, not incremented.
- SYS_TIME already past the value when latched: switch in the first WAIT_TRANS cycle.
- Reset mid-operation: immediate return to reset values; pending request is lost.

Decomposition:
- Package mod_sched_pkg:
  - typedef transition_mode_t (enum: SYNC_IDX=8'h00, SYS_TIME=8'h01, GPIO=8'h02, IMMEDIATE=8'hFF).
  - State enum.
  - Constant REP_INFINITE=16'hFFFF.
- One sub-module: mod_transition_trigger.
  - Inputs: pending mode/value, wrap event, SYS_TIME, GPIO_IN.
  - Output: one-bit fire; owns the GPIO edge register.

Test Plan:
- Reset, REP[0]=FFFF, CYCLE[0]=3, IDX_IN cycling 0..3 for 10 loops -> SEGMENT=0, STOP never asserted.
- UPDATE req=1, mode FF -> SEGMENT=1 and SEG_CHANGED pulse exactly 2 cycles after UPDATE; BUSY high 1 cycle.
- Segment 1 CYCLE=4, REP=2, IDX_IN cycling -> STOP asserts on the third wrap (15 samples after switch) and stays high while IDX continues.
- Mode 00 with IDX_IN at 1 of CYCLE=3 -> switch occurs on the cycle IDX_IN returns to 0, not earlier.
- Mode 01 value=1000, SYS_TIME ramps from 990 -> switch on the cycle SYS_TIME==1000. A second UPDATE at SYS_TIME=995 with value 2000 -> no switch at 1000; switch at 2000.
- Mode 02 value=2, pulse GPIO_IN[1] then GPIO_IN[2] -> no switch on bit 1; switch on bit-2 rising edge. Holding GPIO_IN[2] high before UPDATE -> no switch until next rising edge.
